// File: rtl/mac_tile_sequencer.sv
// Sequences one shared signed MAC across a ROWS x COLS output tile of K-long
// dot products: issues A/B operand reads, aligns the MAC enable to the
// 1-cycle buffer latency, clears the accumulator between elements and streams
// each result out on a valid/ready port.
module mac_tile_sequencer #(
    parameter int unsigned DIM_W  = 8,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  cfg_k,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [DIM_W-1:0]  cfg_cols,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              mac_en,
    output logic              mac_clr_n,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [DIM_W-1:0]  out_row,
    output logic [DIM_W-1:0]  out_col
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DIM_W-1:0]    r_cfg_k;
    logic [DIM_W-1:0]    r_cfg_rows;
    logic [DIM_W-1:0]    r_cfg_cols;
    logic [DIM_W-1:0]    r_row;
    logic [DIM_W-1:0]    r_col;
    logic [DIM_W-1:0]    r_k;
    logic [ADDR_W-1:0]   r_a_base;
    logic [ADDR_W-1:0]   r_a_ptr;
    logic [ADDR_W-1:0]   r_b_ptr;

    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_rd_en;
    logic                r_mac_en;
    logic                r_mac_clr_n;
    logic                r_out_valid;

    logic                w_cfg_zero;
    logic                w_cfg_err;
    logic                w_accept;
    logic                w_last_k;
    logic                w_last_col;
    logic                w_last_row;

    assign w_cfg_zero = (cfg_k == '0) || (cfg_rows == '0) || (cfg_cols == '0);
    assign w_accept   = (r_state == S_OUTPUT) && out_ready;
    assign w_last_k   = (r_k   == r_cfg_k    - DIM_W'(1));
    assign w_last_col = (r_col == r_cfg_cols - DIM_W'(1));
    assign w_last_row = (r_row == r_cfg_rows - DIM_W'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        w_cfg_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_cfg_zero) begin
                        w_cfg_err = 1'b1;
                    end else begin
                        w_state_nxt = S_CLEAR;
                    end
                end
            end
            S_CLEAR:  w_state_nxt = S_ISSUE;
            S_ISSUE:  if (w_last_k) w_state_nxt = S_DRAIN;
            S_DRAIN:  w_state_nxt = S_OUTPUT;
            S_OUTPUT: begin
                if (w_accept) begin
                    w_state_nxt = (w_last_col && w_last_row) ? S_DONE : S_CLEAR;
                end
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_cfg_err   = 1'b0;
        end
    end

    // Config capture, tile counters and operand address pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_k    <= '0;
            r_cfg_rows <= '0;
            r_cfg_cols <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_k        <= '0;
            r_a_base   <= '0;
            r_a_ptr    <= '0;
            r_b_ptr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cfg_k    <= cfg_k;
                        r_cfg_rows <= cfg_rows;
                        r_cfg_cols <= cfg_cols;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_k        <= '0;
                        r_a_base   <= '0;
                    end
                end
                S_CLEAR: begin
                    r_a_ptr <= r_a_base;
                    r_b_ptr <= ADDR_W'(r_col);
                    r_k     <= '0;
                end
                S_ISSUE: begin
                    r_a_ptr <= r_a_ptr + ADDR_W'(1);
                    r_b_ptr <= r_b_ptr + ADDR_W'(r_cfg_cols);
                    r_k     <= r_k + DIM_W'(1);
                end
                S_OUTPUT: begin
                    if (w_accept) begin
                        if (!w_last_col) begin
                            r_col <= r_col + DIM_W'(1);
                        end else if (!w_last_row) begin
                            r_col    <= '0;
                            r_row    <= r_row + DIM_W'(1);
                            r_a_base <= r_a_base + ADDR_W'(r_cfg_k);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered control outputs, decoded from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rd_en     <= 1'b0;
            r_mac_en    <= 1'b0;
            r_mac_clr_n <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE) || w_cfg_err;
            r_err       <= w_cfg_err;
            r_rd_en     <= (w_state_nxt == S_ISSUE);
            r_mac_en    <= r_rd_en && !abort;
            r_mac_clr_n <= (w_state_nxt != S_CLEAR);
            r_out_valid <= (w_state_nxt == S_OUTPUT);
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign rd_en     = r_rd_en;
    assign a_addr    = r_a_ptr;
    assign b_addr    = r_b_ptr;
    assign mac_en    = r_mac_en;
    assign mac_clr_n = r_mac_clr_n;
    assign out_valid = r_out_valid;
    assign out_data  = mac_acc;
    assign out_row   = r_row;
    assign out_col   = r_col;

endmodule

// File: tb/tb_mac_tile_sequencer.sv
// Directed bench for mac_tile_sequencer with an operand-buffer and MAC model.
module tb_mac_tile_sequencer;

    localparam int unsigned DIM_W  = 8;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned ACC_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [DIM_W-1:0]  cfg_k;
    logic [DIM_W-1:0]  cfg_rows;
    logic [DIM_W-1:0]  cfg_cols;
    logic              busy;
    logic              done;
    logic              err;
    logic              rd_en;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic              mac_en;
    logic              mac_clr_n;
    logic [ACC_W-1:0]  mac_acc;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [DIM_W-1:0]  out_row;
    logic [DIM_W-1:0]  out_col;

    mac_tile_sequencer #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_k(cfg_k), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
        .mac_en(mac_en), .mac_clr_n(mac_clr_n), .mac_acc(mac_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col)
    );

    always #5 clk = ~clk;

    // Operand buffers with 1-cycle read latency and a signed MAC.
    logic signed [7:0]  mem_a [0:4095];
    logic signed [7:0]  mem_b [0:4095];
    logic signed [7:0]  a_q, b_q;
    logic signed [15:0] prod;
    assign prod = a_q * b_q;

    always @(posedge clk) begin
        if (rd_en) begin
            a_q <= mem_a[a_addr];
            b_q <= mem_b[b_addr];
        end
    end

    always @(posedge clk) begin
        if (!mac_clr_n)  mac_acc <= '0;
        else if (mac_en) mac_acc <= mac_acc + {{16{prod[15]}}, prod};
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else             n_pass++;
    endtask

    // Per-tile observations.
    int          q_row[$];
    int          q_col[$];
    logic [31:0] q_data[$];
    int          rd_cnt, done_cnt, stab_err, err_seen;
    int          first_a, first_b, last_a, last_b;

    task automatic load_t1();
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        for (int i = 0; i < 6; i++) mem_a[i] = 8'(i + 1);
        mem_b[0] = 8'sd1; mem_b[1] = 8'sd0; mem_b[2] = 8'sd0;
        mem_b[3] = 8'sd1; mem_b[4] = 8'sd1; mem_b[5] = 8'sd1;
    endtask

    // Start a tile and follow it to done; stall>0 holds out_ready low that many cycles per result.
    task automatic run_tile(input int kk, input int rr, input int cc, input int stall, output int cyc);
        int          st;
        logic        hold_v;
        logic [31:0] hd;
        logic [7:0]  hr, hc;
        q_row.delete(); q_col.delete(); q_data.delete();
        rd_cnt = 0; done_cnt = 0; stab_err = 0; err_seen = 0;
        first_a = -1; first_b = -1; last_a = -1; last_b = -1;
        hold_v = 1'b0; hd = '0; hr = '0; hc = '0; st = 0; cyc = 0;
        @(negedge clk);
        cfg_k = 8'(kk); cfg_rows = 8'(rr); cfg_cols = 8'(cc);
        start = 1'b1;
        out_ready = (stall == 0);
        for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
            @(negedge clk);
            start = 1'b0;
            cfg_k = 8'd7; cfg_rows = 8'd9; cfg_cols = 8'd5;
            cyc++;
            if (rd_en) begin
                if (rd_cnt == 0) begin
                    first_a = int'(a_addr);
                    first_b = int'(b_addr);
                end
                last_a = int'(a_addr);
                last_b = int'(b_addr);
                rd_cnt++;
            end
            if (hold_v && (!out_valid || out_data != hd || out_row != hr || out_col != hc)) stab_err++;
            if (done) begin
                done_cnt++;
                err_seen = int'(err);
            end
            if (stall > 0) begin
                if (out_valid && st < stall) begin
                    out_ready = 1'b0;
                    st++;
                end else begin
                    out_ready = out_valid;
                    if (!out_valid) st = 0;
                end
            end
            hold_v = out_valid && !out_ready;
            hd = out_data; hr = out_row; hc = out_col;
            if (out_valid && out_ready) begin
                q_row.push_back(int'(out_row));
                q_col.push_back(int'(out_col));
                q_data.push_back(out_data);
            end
        end
        @(negedge clk);
        if (done) done_cnt++;
        check("busy_after_done", 32'(busy), 32'd0);
        out_ready = 1'b1;
    endtask

    task automatic check_t1(input string pfx);
        int ed[4];
        ed = '{4, 5, 10, 11};
        check({pfx, "_nres"}, 32'(q_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            check($sformatf("%s_data%0d", pfx, i), q_data[i], 32'(ed[i]));
            check($sformatf("%s_row%0d", pfx, i), 32'(q_row[i]), 32'(i / 2));
            check($sformatf("%s_col%0d", pfx, i), 32'(q_col[i]), 32'(i % 2));
        end
        check({pfx, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({pfx, "_err"}, 32'(err_seen), 32'd0);
        check({pfx, "_rd_cnt"}, 32'(rd_cnt), 32'd12);
        check({pfx, "_stable"}, 32'(stab_err), 32'd0);
    endtask

    initial begin
        int cyc;
        int bad;
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        cfg_k = '0; cfg_rows = '0; cfg_cols = '0;
        load_t1();
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mac_clr_n", 32'(mac_clr_n), 32'd0);
        check("rst_a_addr", 32'(a_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_mac_clr_n", 32'(mac_clr_n), 32'd1);

        // 2x2 tile, K=3, always ready.
        run_tile(3, 2, 2, 0, cyc);
        check_t1("t1");
        check("t1_cycles", 32'(cyc + 1), 32'd26);

        // Same tile with 5-cycle backpressure on every result.
        run_tile(3, 2, 2, 5, cyc);
        check_t1("t2");

        // Zero dimension: immediate error completion.
        @(negedge clk);
        cfg_k = 8'd3; cfg_rows = 8'd2; cfg_cols = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t3_done", 32'(done), 32'd1);
        check("t3_err", 32'(err), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rd_en || busy || done) bad++;
        end
        check("t3_quiet_after", 32'(bad), 32'd0);

        // K=255 1x1 with all operands -128.
        for (int i = 0; i < 255; i++) begin
            mem_a[i] = -8'sd128;
            mem_b[i] = -8'sd128;
        end
        run_tile(255, 1, 1, 0, cyc);
        check("t4_nres", 32'(q_data.size()), 32'd1);
        if (q_data.size() > 0) check("t4_data", q_data[0], 32'd4177920);
        check("t4_rd_cnt", 32'(rd_cnt), 32'd255);
        check("t4_first_a", 32'(first_a), 32'd0);
        check("t4_last_a", 32'(last_a), 32'd254);
        check("t4_first_b", 32'(first_b), 32'd0);
        check("t4_last_b", 32'(last_b), 32'd254);
        check("t4_cycles", 32'(cyc + 1), 32'd260);

        // Abort during ISSUE at k=2, then rerun the 2x2 tile.
        load_t1();
        @(negedge clk);
        cfg_k = 8'd3; cfg_rows = 8'd2; cfg_cols = 8'd2; start = 1'b1;
        bad = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (rd_en && a_addr == 12'd2) begin
                bad = 0;
                break;
            end
        end
        check("t5_reached_k2", 32'(bad), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_rd_en", 32'(rd_en), 32'd0);
        check("t5_mac_en", 32'(mac_en), 32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || done || busy || rd_en) bad++;
        end
        check("t5_quiet_after", 32'(bad), 32'd0);
        run_tile(3, 2, 2, 0, cyc);
        check_t1("t5r");

        // Reset pulse while a result is waiting.
        @(negedge clk);
        cfg_k = 8'd3; cfg_rows = 8'd1; cfg_cols = 8'd1; start = 1'b1; out_ready = 1'b0;
        bad = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid) begin
                bad = 0;
                break;
            end
        end
        check("t6_reached_output", 32'(bad), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_mac_clr_n", 32'(mac_clr_n), 32'd0);
        check("t6_rd_en", 32'(rd_en), 32'd0);
        check("t6_out_row", 32'(out_row), 32'd0);
        @(negedge clk);
        check("t6_mac_clr_n_held", 32'(mac_clr_n), 32'd0);
        check("t6_acc_cleared", mac_acc, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_mac_clr_n_rel", 32'(mac_clr_n), 32'd1);
        check("t6_idle_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
